// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state, w_state_next;
  logic             w_accept, w_last;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-2:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             w_d, w_br_next;
  logic [WIDTH-1:0] w_res_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = StShift;
        end
      end
      StShift: begin
        busy = 1'b1;
        if (r_cnt == LastBit) begin
          w_last       = 1'b1;
          w_state_next = StDone;
        end
      end
      StDone: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    w_d        = r_a[0] ^ r_b[0] ^ r_br;
    w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    w_res_next = {w_d, r_res};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (r_state == StShift) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_br_next;
      r_res <= w_res_next[WIDTH-1:1];
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff <= w_res_next;
        r_bout <= w_br_next;
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // On the last bit the operand LSBs are the original MSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8), random and directed operations.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic       busy, done, bout;
  logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t hold;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
    exp_t e;
    int   d;
    d      = int'(ma) - int'(mb) - int'(mbin);
    e.diff = d[7:0];
    e.bout = (d < 0);
    e.ovf  = (ma[7] != mb[7]) && (e.diff[7] != ma[7]);
    return e;
  endfunction

  // Monitor: pop on done, otherwise results must hold their last value.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          hold = sb_q.pop_front();
          check("diff", {24'd0, diff}, {24'd0, hold.diff});
          check("bout", {31'd0, bout}, {31'd0, hold.bout});
`ifdef SERIAL_SUB_OVF_EN
          check("ovf", {31'd0, ovf}, {31'd0, hold.ovf});
`endif
        end
      end else if (busy === 1'b1) begin
        check("diff_hold", {24'd0, diff}, {24'd0, hold.diff});
        check("bout_hold", {31'd0, bout}, {31'd0, hold.bout});
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
    int n = 0;
    wait_idle();
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    sb_q.push_back(model(ia, ib, ibin));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    bin   = 1'($urandom);
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
    end
    check("latency", n, WIDTH);
    @(negedge clk);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("done_after", {31'd0, done}, 32'd0);
  endtask

  task automatic back_to_back(input logic [7:0] a1, input logic [7:0] b1,
                              input logic [7:0] a2, input logic [7:0] b2, input logic bin2);
    int n = 0;
    int seen = 0;
    int first = 0;
    int second = 0;
    wait_idle();
    a     = a1;
    b     = b1;
    bin   = 1'b0;
    start = 1'b1;
    sb_q.push_back(model(a1, b1, 1'b0));
    sb_q.push_back(model(a2, b2, bin2));
    @(posedge clk);
    #1;
    a   = a2;
    b   = b2;
    bin = bin2;
    while (seen < 2 && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 10) start = 1'b0;
      if (n == 9) check("b2b_gap_busy", {31'd0, busy}, 32'd0);
      if (done) begin
        seen++;
        if (seen == 1) first = n;
        else second = n;
      end
    end
    start = 1'b0;
    check("b2b_first_done", first, 8);
    check("b2b_second_done", second, 18);
  endtask

  task automatic reset_mid_op();
    wait_idle();
    a     = 8'hAA;
    b     = 8'h55;
    bin   = 1'b0;
    start = 1'b1;
    sb_q.push_back(model(8'hAA, 8'h55, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    hold = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    hold  = '0;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_diff", {24'd0, diff}, 32'd0);
    check("reset_bout", {31'd0, bout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h10, 8'h10, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h00, 8'hFF, 1'b1);
    run_op(8'h7F, 8'h80, 1'b0);
    run_op(8'h80, 8'h7F, 1'b1);
    run_op(8'h80, 8'h00, 1'b1);
    back_to_back(8'h3C, 8'h5A, 8'hC3, 8'h21, 1'b1);
    run_op(8'h10, 8'h10, 1'b1);
    reset_mid_op();
    run_op(8'hAA, 8'h55, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
